rcs_seq_addsub: RTL

Parametrised, multi-cycle ripple add/subtract unit and the successor of the 8-bit combinational ripple-carry subtractor. It takes one operand pair per transaction over a valid/ready handshake. It processes DIGIT bits per clock through a registered carry chain and returns the result with carry, signed-overflow and zero flags over a second valid/ready handshake. It sits between operand-producing control logic and result consumers wherever a wide add/sub is needed without a long combinational carry path.

---
 rtl/rcs_seq_addsub.sv | 134 +++++++++++++
 1 files changed

// File: rtl/rcs_seq_addsub.sv
`default_nettype none
// ============================================================================
// Module   : rcs_seq_addsub
// Brief    : Multi-cycle ripple add/subtract unit. Consumes DIGIT bits per
//            clock through a registered carry, returns result plus carry,
//            signed-overflow and zero flags over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module rcs_seq_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  input  logic             in_Cin,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_Res,
  output logic             out_Cout,
  output logic             out_Ovf,
  output logic             out_Zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    step;

  logic             accept;
  logic             run_step;
  logic             last_step;
  logic [DIGIT:0]   digit_sum;
  logic             msb_cin;
  logic [WIDTH-1:0] res_next;

  // Reset dominates the ready indication so nothing is taken while rst is high.
  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;
  assign run_step  = (state == S_RUN);
  assign last_step = run_step && (step == LAST_STEP);

  // One digit of the ripple chain; carry stays registered between digits.
  assign digit_sum = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};

  // Carry into the MSB recovered from the MSB's own sum bit and operands.
  assign msb_cin = a_sr[DIGIT-1] ^ b_sr[DIGIT-1] ^ digit_sum[DIGIT-1];

  // The result shift register holds only the upper WIDTH-DIGIT bits; the
  // current digit always supplies the top, so the final value needs no
  // extra shift cycle.
  generate
    if (N > 1) begin : g_multi_step
      logic [WIDTH-DIGIT-1:0] res_sr;

      assign res_next = {digit_sum[DIGIT-1:0], res_sr};

      // Accumulate completed digits, lowest digit ending at bit 0.
      always_ff @(posedge clk) begin
        if (rst) begin
          res_sr <= '0;
        end else if (run_step) begin
          res_sr <= res_next[WIDTH-1:DIGIT];
        end
      end
    end else begin : g_single_step
      assign res_next = digit_sum[DIGIT-1:0];
    end
  endgenerate

  // Control FSM, operand shifters, carry and result/flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      carry    <= 1'b0;
      step     <= '0;
      out_Res  <= '0;
      out_Cout <= 1'b0;
      out_Ovf  <= 1'b0;
      out_Zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_sr  <= in_A;
            b_sr  <= in_mode ? ~in_B : in_B;
            carry <= in_Cin;
            step  <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          a_sr  <= a_sr >> DIGIT;
          b_sr  <= b_sr >> DIGIT;
          carry <= digit_sum[DIGIT];
          step  <= step + 1'b1;
          if (last_step) begin
            out_Res  <= res_next;
            out_Cout <= digit_sum[DIGIT];
            out_Ovf  <= msb_cin ^ digit_sum[DIGIT];
            out_Zero <= (res_next == '0);
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
